// File: rtl/mm_job_sched_if.sv
// mm_job_sched_if: job, engine and done handshakes between a job source/engine and mm_job_sched.
interface mm_job_sched_if #(
    parameter int L = 20
);
    logic         job_valid;
    logic         job_ready;
    logic [L-1:0] job_a;
    logic [L-1:0] job_b;
    logic [L-1:0] job_c;
    logic [3:0]   job_id;
    logic         mm_start;
    logic         mm_abort;
    logic [L-1:0] mm_a;
    logic [L-1:0] mm_b;
    logic [L-1:0] mm_c;
    logic         mm_finish;
    logic         done_valid;
    logic         done_ready;
    logic [3:0]   done_id;
    logic         done_err;

    modport master (
        output job_valid, job_a, job_b, job_c, job_id, mm_finish, done_ready,
        input  job_ready, mm_start, mm_abort, mm_a, mm_b, mm_c, done_valid, done_id, done_err
    );

    modport slave (
        input  job_valid, job_a, job_b, job_c, job_id, mm_finish, done_ready,
        output job_ready, mm_start, mm_abort, mm_a, mm_b, mm_c, done_valid, done_id, done_err
    );
endinterface

// File: rtl/mm_job_sched.sv
// mm_job_sched: queues matrix-multiply job descriptors, launches them on the engine one at a time,
// enforces a RUN timeout and reports each job's completion with an error flag.
module mm_job_sched #(
    parameter int L     = 20,
    parameter int DEPTH = 4,
    parameter int TMO   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    mm_job_sched_if.slave bus,
    output logic          busy,
    output logic [15:0]   jobs_done,
    output logic [7:0]    err_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = TMO > 1 ? $clog2(TMO) : 1;
    localparam int DW = 3 * L + 4;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tcnt;
    logic          push, pop, tmo_hit;
    logic [L-1:0]  ha, hb, hc;
    logic [3:0]    hid;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign bus.job_ready     = count < CW'(DEPTH);
    assign push              = bus.job_valid && bus.job_ready;
    assign pop               = state == IDLE && count != '0;
    assign {hid, hc, hb, ha} = mem[rd_ptr];
    assign tmo_hit           = state == RUN && tcnt == TW'(TMO - 1);
    // Combinational so that a finish arriving in the timeout cycle can still veto the abort.
    assign bus.mm_abort      = tmo_hit && !bus.mm_finish;
    assign busy              = state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {bus.job_id, bus.job_c, bus.job_b, bus.job_a};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tcnt           <= '0;
            bus.mm_start   <= 1'b0;
            bus.mm_a       <= '0;
            bus.mm_b       <= '0;
            bus.mm_c       <= '0;
            bus.done_valid <= 1'b0;
            bus.done_id    <= '0;
            bus.done_err   <= 1'b0;
            jobs_done      <= '0;
            err_count      <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count        <= count + CW'(push) - CW'(pop);
            bus.mm_start <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    bus.mm_a    <= ha;
                    bus.mm_b    <= hb;
                    bus.mm_c    <= hc;
                    bus.done_id <= hid;
                    if (ha == '0 || hb == '0 || hc == '0) begin
                        bus.done_err   <= 1'b1;
                        bus.done_valid <= 1'b1;
                        state          <= REPORT;
                    end else
                        state <= LAUNCH;
                end
                LAUNCH: begin
                    bus.mm_start <= 1'b1;
                    tcnt         <= '0;
                    state        <= RUN;
                end
                RUN: begin
                    tcnt <= tcnt + TW'(1);
                    if (bus.mm_finish || tmo_hit) begin
                        bus.done_err   <= !bus.mm_finish;
                        bus.done_valid <= 1'b1;
                        state          <= REPORT;
                    end
                end
                REPORT: if (bus.done_ready) begin
                    bus.done_valid <= 1'b0;
                    jobs_done      <= jobs_done + 16'd1;
                    if (bus.done_err && err_count != 8'hff) err_count <= err_count + 8'd1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mm_job_sched.sv
// tb_mm_job_sched: directed and randomized checks of mm_job_sched against a per-job timeline model;
// a long-timeout and a short-timeout instance are multiplexed onto one set of bench signals.
module tb_mm_job_sched;
    localparam int L     = 20;
    localparam int DEPTH = 4;
    localparam int TMO_S = 16;
    localparam int TMO_L = 4096;

    typedef struct packed {logic [L-1:0] a, b, c; logic [3:0] id;} job_t;

    logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
    logic job_valid = 1'b0, mm_finish = 1'b0, done_ready = 1'b0;
    logic [L-1:0] job_a = '0, job_b = '0, job_c = '0;
    logic [3:0] job_id = '0;
    logic job_ready_o, mm_start_o, mm_abort_o, dv_o, derr_o, busy_o, busy_l, busy_s;
    logic [L-1:0] ma_o, mb_o, mc_o;
    logic [3:0] did_o;
    logic [15:0] jd_o, jd_l, jd_s;
    logic [7:0] ec_o, ec_l, ec_s;

    mm_job_sched_if #(.L(L)) ifl ();
    mm_job_sched_if #(.L(L)) ifs ();

    mm_job_sched #(.L(L), .DEPTH(DEPTH)) u_long (
        .clk(clk), .reset(reset), .bus(ifl), .busy(busy_l), .jobs_done(jd_l), .err_count(ec_l));
    mm_job_sched #(.L(L), .DEPTH(DEPTH), .TMO(TMO_S)) u_short (
        .clk(clk), .reset(reset), .bus(ifs), .busy(busy_s), .jobs_done(jd_s), .err_count(ec_s));

    assign ifl.job_valid  = job_valid && !sel;
    assign ifs.job_valid  = job_valid && sel;
    assign ifl.mm_finish  = mm_finish && !sel;
    assign ifs.mm_finish  = mm_finish && sel;
    assign ifl.done_ready = done_ready && !sel;
    assign ifs.done_ready = done_ready && sel;
    assign ifl.job_a = job_a;
    assign ifl.job_b = job_b;
    assign ifl.job_c = job_c;
    assign ifl.job_id = job_id;
    assign ifs.job_a = job_a;
    assign ifs.job_b = job_b;
    assign ifs.job_c = job_c;
    assign ifs.job_id = job_id;
    assign job_ready_o = sel ? ifs.job_ready : ifl.job_ready;
    assign mm_start_o  = sel ? ifs.mm_start : ifl.mm_start;
    assign mm_abort_o  = sel ? ifs.mm_abort : ifl.mm_abort;
    assign ma_o        = sel ? ifs.mm_a : ifl.mm_a;
    assign mb_o        = sel ? ifs.mm_b : ifl.mm_b;
    assign mc_o        = sel ? ifs.mm_c : ifl.mm_c;
    assign dv_o        = sel ? ifs.done_valid : ifl.done_valid;
    assign did_o       = sel ? ifs.done_id : ifl.done_id;
    assign derr_o      = sel ? ifs.done_err : ifl.done_err;
    assign busy_o      = sel ? busy_s : busy_l;
    assign jd_o        = sel ? jd_s : jd_l;
    assign ec_o        = sel ? ec_s : ec_l;

    always #5 clk = ~clk;

    // Model: queued jobs plus the in-flight job described by its age in cycles since it was popped.
    job_t pend[$];
    job_t cur;
    bit inflight, zero, err_m, last_acc, spur;
    int age, rep_age, fin, fin_set, tmo, cyc, jd, errc;
    int n_start, n_abort, start_cyc, abort_cyc, acc_cyc;
    logic [3:0] done_ids[$];
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        cur = '0;
        inflight = 0;
        zero = 0;
        err_m = 0;
        age = 0;
        rep_age = 0;
        fin = 0;
        jd = 0;
        errc = 0;
    endtask

    function automatic bit in_run();
        return inflight && !zero && age >= 2 && age < rep_age;
    endfunction

    task automatic model_edge();
        bit acc, pp, hs;
        acc = job_valid && pend.size() < DEPTH;
        pp = !inflight && pend.size() > 0;
        hs = inflight && age >= rep_age && done_ready;
        last_acc = acc;
        if (acc) acc_cyc = cyc;
        if (hs) begin
            jd = (jd + 1) % 65536;
            if (err_m && errc < 255) errc++;
            inflight = 0;
        end else if (inflight) age++;
        if (pp) begin
            cur = pend.pop_front();
            inflight = 1;
            age = 1;
            zero = cur.a == 0 || cur.b == 0 || cur.c == 0;
            fin = fin_set > 0 ? fin_set : int'($urandom_range(1, tmo + 4));
            rep_age = zero ? 1 : (fin < tmo ? fin : tmo) + 2;
            if (zero) err_m = 1;
        end else if (inflight && !zero && age == rep_age) err_m = fin > tmo;
        if (acc) pend.push_back('{job_a, job_b, job_c, job_id});
    endtask

    task automatic check_all();
        bit run;
        run = in_run();
        chk("job_ready", job_ready_o, pend.size() < DEPTH);
        chk("busy", busy_o, inflight);
        chk("mm_start", mm_start_o, inflight && !zero && age == 2);
        chk("mm_abort", mm_abort_o, run && age == tmo + 1 && fin > tmo);
        chk("mm_dims", {ma_o, mb_o, mc_o}, {cur.a, cur.b, cur.c});
        chk("done_valid", dv_o, inflight && age >= rep_age);
        chk("done_id", did_o, cur.id);
        chk("done_err", derr_o, err_m);
        chk("jobs_done", jd_o, 64'(jd));
        chk("err_count", ec_o, 64'(errc));
    endtask

    task automatic step();
        if (dv_o && done_ready) done_ids.push_back(did_o);
        @(posedge clk);
        cyc++;
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        mm_finish = in_run() ? (age == fin + 1 && fin <= tmo) : (spur && $urandom_range(0, 3) == 0);
        #1;
        check_all();
        if (mm_start_o) begin
            n_start++;
            start_cyc = cyc;
        end
        if (mm_abort_o) begin
            n_abort++;
            abort_cyc = cyc;
        end
    endtask

    task automatic push(input int a, input int b, input int c, input int id);
        job_a = L'(a);
        job_b = L'(b);
        job_c = L'(c);
        job_id = 4'(id);
        job_valid = 1;
        last_acc = 0;
        for (int i = 0; i < 200 && !last_acc; i++) step();
        chk("accept", last_acc, 1);
        job_valid = 0;
    endtask

    task automatic wait_dv(input int bound);
        for (int i = 0; i < bound && !dv_o; i++) step();
        chk("done_seen", dv_o, 1);
    endtask

    task automatic wait_idle(input int bound);
        done_ready = 1;
        for (int i = 0; i < bound && (inflight || pend.size() != 0); i++) step();
        chk("drain_busy", busy_o, 0);
    endtask

    function automatic logic [L-1:0] rnd_dim();
        return $urandom_range(0, 9) == 0 ? '0 : L'($urandom_range(1, 1000));
    endfunction

    initial begin
        int s0, a0, h;
        tmo = TMO_L;
        spur = 0;
        fin_set = 0;
        cyc = 0;
        n_start = 0;
        n_abort = 0;
        #1 reset = 0;
        model_reset();
        #1 check_all();
        step();
        step();
        reset = 1;

        fin_set = 21;
        done_ready = 1;
        push(2, 3, 2, 5);
        wait_dv(100);
        chk("lat_start", 64'(start_cyc - acc_cyc), 2);
        chk("dims_232", {ma_o, mb_o, mc_o}, {20'd2, 20'd3, 20'd2});
        chk("id5", did_o, 5);
        chk("id5_err", derr_o, 0);
        wait_idle(100);
        chk("jobs_done_1", jd_o, 1);

        s0 = n_start;
        push(5, 0, 7, 9);
        wait_dv(20);
        chk("zero_id", did_o, 9);
        chk("zero_err", derr_o, 1);
        wait_idle(20);
        chk("zero_nostart", 64'(n_start - s0), 0);
        chk("zero_errcnt", ec_o, 1);

        fin_set = 30;
        done_ids.delete();
        for (int i = 1; i <= 5; i++) push(3, 3, 3, i);
        chk("fifo_full", job_ready_o, 0);
        chk("first_running", busy_o, 1);
        wait_idle(1000);
        chk("order_len", 64'(done_ids.size()), 5);
        for (int i = 0; i < done_ids.size(); i++) chk("order_id", done_ids[i], 64'(i + 1));

        fin_set = 3;
        done_ready = 0;
        push(4, 4, 4, 1);
        push(4, 4, 4, 2);
        wait_dv(50);
        s0 = n_start;
        repeat (10) step();
        chk("hold_nostart", 64'(n_start - s0), 0);
        chk("hold_id", did_o, 1);
        chk("hold_valid", dv_o, 1);
        done_ready = 1;
        h = cyc + 1;
        start_cyc = -100;
        for (int i = 0; i < 6 && !mm_start_o; i++) step();
        chk("resume_lat", 64'(start_cyc - h), 2);
        wait_idle(100);

        #2 reset = 0;
        sel = 1;
        tmo = TMO_S;
        model_reset();
        step();
        reset = 1;

        fin_set = 100000;
        abort_cyc = -100;
        push(3, 3, 3, 2);
        wait_dv(100);
        chk("tmo_abort_cycle", 64'(abort_cyc - start_cyc), 15);
        chk("tmo_err", derr_o, 1);
        wait_idle(50);
        a0 = n_abort;
        fin_set = TMO_S;
        push(3, 3, 3, 3);
        wait_dv(100);
        chk("finish_wins_abort", 64'(n_abort - a0), 0);
        chk("finish_wins_err", derr_o, 0);
        wait_idle(50);

        fin_set = 0;
        spur = 1;
        for (int i = 0; i < 2000; i++) begin
            job_valid = $urandom_range(0, 2) != 0;
            job_a = rnd_dim();
            job_b = rnd_dim();
            job_c = rnd_dim();
            job_id = 4'($urandom);
            done_ready = $urandom_range(0, 3) != 0;
            step();
        end
        job_valid = 0;
        spur = 0;
        wait_idle(2000);

        fin_set = 100000;
        for (int i = 0; i < 4; i++) push(6, 6, 6, 10 + i);
        step();
        chk("pre_rst_queued", job_ready_o, 1);
        chk("pre_rst_busy", busy_o, 1);
        a0 = n_abort;
        #2 reset = 0;
        model_reset();
        #1 check_all();
        repeat (3) step();
        reset = 1;
        chk("rst_noabort", 64'(n_abort - a0), 0);
        fin_set = 5;
        push(2, 2, 2, 7);
        wait_idle(100);
        chk("post_rst_jobs", jd_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
